// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scanner for an NDIG-digit 7-segment display.
// Each frame latches a hex word and a decimal-point mask, then visits each digit
// for SCAN_DIV cycles. The first cycle of every digit slot is a dark guard cycle.
// Optional leading-zero suppression keeps blank leading digits dark.
module seg7_scan_ctrl #(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              LZ_EN,
  input  logic [4*NDIG-1:0] DATA,
  input  logic [NDIG-1:0]   DP_IN,
  output logic [3:0]        HEX,
  output logic              DP,
  output logic [NDIG-1:0]   DIGIT_SEL,
  output logic              FRAME
);

  localparam int SW = $clog2(NDIG);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NDIG - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [DW-1:0]       div_q, div_d;
  logic [4*NDIG-1:0]   data_q, data_d;
  logic [NDIG-1:0]     dpm_q, dpm_d;
  logic [NDIG-1:0]     supp_q, supp_d;
  logic [3:0]          hex_q, hex_d;
  logic                dp_q, dp_d;
  logic [NDIG-1:0]     sel_q, sel_d;
  logic                frame_q, frame_d;
  logic                take;

  // A digit is blanked when it and every more-significant digit are zero with no
  // decimal point; digit 0 always stays lit so a zero value still shows "0".
  function automatic logic [NDIG-1:0] lz_mask(input logic [4*NDIG-1:0] d,
                                              input logic [NDIG-1:0]   dp,
                                              input logic              lz);
    logic [NDIG-1:0] m;
    logic            run;
    m   = '0;
    run = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      run  = run & (d[4*i +: 4] == 4'h0) & ~dp[i];
      m[i] = run & lz;
    end
    return m;
  endfunction

  // Next-state: scan counters, frame snapshot, and outputs derived from the
  // post-edge slot/div so the registered outputs line up with the counters.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    div_d   = div_q;
    data_d  = data_q;
    dpm_d   = dpm_q;
    supp_d  = supp_q;
    take    = 1'b0;

    if (!EN) begin
      state_d = IDLE;
      slot_d  = '0;
      div_d   = '0;
    end else if (state_q == IDLE) begin
      state_d = SCAN;
      slot_d  = '0;
      div_d   = '0;
      take    = 1'b1;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      if (slot_q == SLOT_LAST) begin
        slot_d = '0;
        take   = 1'b1;
      end else begin
        slot_d = slot_q + SW'(1);
      end
    end else begin
      div_d = div_q + DW'(1);
    end

    if (take) begin
      data_d = DATA;
      dpm_d  = DP_IN;
      supp_d = lz_mask(DATA, DP_IN, LZ_EN);
    end

    hex_d   = 4'h0;
    dp_d    = 1'b0;
    sel_d   = '0;
    frame_d = 1'b0;
    if (state_d == SCAN) begin
      for (int i = 0; i < NDIG; i++) begin
        if (slot_d == SW'(i)) begin
          hex_d = data_d[4*i +: 4];
          if (div_d != '0 && !supp_d[i]) begin
            sel_d[i] = 1'b1;
            dp_d     = dpm_d[i];
          end
        end
      end
      frame_d = (slot_d == SLOT_LAST) && (div_d == DIV_LAST);
    end
  end

  // State, snapshot and output registers; async reset darkens the display at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      slot_q  <= '0;
      div_q   <= '0;
      data_q  <= '0;
      dpm_q   <= '0;
      supp_q  <= '0;
      hex_q   <= 4'h0;
      dp_q    <= 1'b0;
      sel_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      div_q   <= div_d;
      data_q  <= data_d;
      dpm_q   <= dpm_d;
      supp_q  <= supp_d;
      hex_q   <= hex_d;
      dp_q    <= dp_d;
      sel_q   <= sel_d;
      frame_q <= frame_d;
    end
  end

  assign HEX       = hex_q;
  assign DP        = dp_q;
  assign DIGIT_SEL = sel_q;
  assign FRAME     = frame_q;

endmodule
